// File: rtl/motion_cmd_sequencer_if.sv
// Key/collision inputs and motion command outputs of the motion command sequencer.
// Latency: none (wires only).
// Backpressure: none; commands are strobes and the datapath must accept each cmdValid.
interface motion_cmd_sequencer_if;
   logic       startOfFrame;
   logic       rightN;
   logic       leftN;
   logic       jumpN;
   logic       collision;
   logic [3:0] HitEdgeCode;
   logic       cmdValid;
   logic [1:0] cmdCode;
   logic       grounded;
   logic [1:0] phase;
   logic [2:0] queueCount;
   logic       cmdDropped;
   logic       airTimeout;

   // Stimulus side: drives keys, frame pulses and collisions, observes commands.
   modport master (
      output startOfFrame, rightN, leftN, jumpN, collision, HitEdgeCode,
      input  cmdValid, cmdCode, grounded, phase, queueCount, cmdDropped, airTimeout
   );

   // Sequencer side.
   modport slave (
      input  startOfFrame, rightN, leftN, jumpN, collision, HitEdgeCode,
      output cmdValid, cmdCode, grounded, phase, queueCount, cmdDropped, airTimeout
   );
endinterface

// File: rtl/motion_cmd_sequencer.sv
// Turns active-low key presses into queued one-clk move commands issued at frame start while grounded.
// Latency: key low to queued = 3 clk; startOfFrame pop to cmdValid = 1 clk.
// Backpressure: none upstream; a press arriving with a full queue is discarded and flagged on cmdDropped.
module motion_cmd_sequencer #(
   parameter int QUEUE_DEPTH    = 2,
   parameter int MIN_AIR_FRAMES = 4,
   parameter int MAX_AIR_FRAMES = 90,
   parameter int SETTLE_FRAMES  = 2
) (
   input logic                   clk,
   input logic                   resetN,
   motion_cmd_sequencer_if.slave bus
);

   localparam logic [2:0] DEPTH_C  = 3'(QUEUE_DEPTH);
   localparam logic [1:0] PTR_LAST = 2'(QUEUE_DEPTH - 1);
   localparam logic [7:0] MIN_A    = 8'(MIN_AIR_FRAMES);
   localparam logic [7:0] MAX_A    = 8'(MAX_AIR_FRAMES);
   localparam logic [7:0] SETTLE_C = 8'(SETTLE_FRAMES);

   typedef enum logic [1:0] {
      ST_GROUND = 2'b00,
      ST_AIR    = 2'b01,
      ST_SETTLE = 2'b10
   } state_t;

   // Key order inside the vectors: {jump, right, left}.
   logic [2:0] key_s1, key_s2, key_prev;
   logic [2:0] press;
   logic       push_vld;
   logic [1:0] push_dat;

   logic [1:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       full, empty, push_ok, drop;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d, cnt_inc;
   logic       land_q, land_d, land_eff, bottom_hit;
   logic       pop, flush, timeout_d;

   logic       cmd_valid_q, dropped_q, timeout_q;
   logic [1:0] cmd_code_q;

   // Only the bottom-edge bit matters to this block.
   logic       unused_edges;
   assign unused_edges = &{1'b0, bus.HitEdgeCode[3:1]};

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         key_s1   <= 3'b111;
         key_s2   <= 3'b111;
         key_prev <= 3'b111;
      end else begin
         key_s1   <= {bus.jumpN, bus.rightN, bus.leftN};
         key_s2   <= key_s1;
         key_prev <= key_s2;
      end
   end

   assign press    = key_prev & ~key_s2;
   assign push_vld = |press;
   assign push_dat = press[2] ? 2'b01 : (press[1] ? 2'b10 : 2'b11);

   assign full    = (count == DEPTH_C);
   assign empty   = (count == 3'd0);
   assign push_ok = push_vld && (!full || pop) && !flush;
   assign drop    = push_vld && full && !pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
   endfunction

   // Command storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= push_dat;
   end

   // Queue pointers and occupancy, with flush on airborne timeout.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else if (flush) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop)     rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   assign bottom_hit = bus.collision && bus.HitEdgeCode[0];
   assign land_eff   = land_q || bottom_hit;

   // Phase state, frame counter and landing flag registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_GROUND;
         cnt_q   <= 8'd0;
         land_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         land_q  <= land_d;
      end
   end

   // Next phase: leave GROUND on an issue, leave AIR on a real landing or timeout, leave SETTLE after the settle frames.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_GROUND: if (bus.startOfFrame && !empty) state_d = ST_AIR;
         ST_AIR: begin
            if (bus.startOfFrame) begin
               if (land_eff && cnt_inc >= MIN_A) state_d = ST_SETTLE;
               else if (cnt_inc == MAX_A)        state_d = ST_GROUND;
            end
         end
         ST_SETTLE: if (bus.startOfFrame && cnt_inc == SETTLE_C) state_d = ST_GROUND;
         default: state_d = ST_GROUND;
      endcase
   end

   // Per-phase actions: pop, counter/landing updates, timeout and flush.
   always_comb begin
      pop       = 1'b0;
      flush     = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      land_d    = land_q;
      case (state_q)
         ST_GROUND: begin
            if (bus.startOfFrame && !empty) begin
               pop    = 1'b1;
               cnt_d  = 8'd0;
               land_d = 1'b0;
            end
         end
         ST_AIR: begin
            land_d = land_eff;
            if (bus.startOfFrame) begin
               cnt_d = cnt_inc;
               if (land_eff && cnt_inc >= MIN_A) begin
                  cnt_d = 8'd0;
               end else if (cnt_inc == MAX_A) begin
                  timeout_d = 1'b1;
                  flush     = 1'b1;
               end else if (cnt_inc < MIN_A) begin
                  // Contact this early is the player leaving the ground, not landing.
                  land_d = 1'b0;
               end
            end
         end
         ST_SETTLE: if (bus.startOfFrame) cnt_d = cnt_inc;
         default: ;
      endcase
   end

   // Registered command strobe/code and single-clk status pulses.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 2'b00;
         dropped_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         cmd_valid_q <= pop;
         if (pop) cmd_code_q <= fifo_mem[rd_ptr];
         dropped_q   <= drop;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.cmdValid   = cmd_valid_q;
   assign bus.cmdCode    = cmd_code_q;
   assign bus.grounded   = (state_q == ST_GROUND);
   assign bus.phase      = state_q;
   assign bus.queueCount = count;
   assign bus.cmdDropped = dropped_q;
   assign bus.airTimeout = timeout_q;

endmodule
